// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t       : FSM state encoding (S_IDLE, S_SHIFT, S_DONE)
//   cnt_width()   : bit counter width for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // $clog2(2) is 1; the guard keeps the counter at least one bit wide.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/adder_1bit.sv
// Combinational one-bit full adder slice.
//   a, b, ci : input bits and carry-in
//   s, co    : sum bit and carry-out
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around adder_1bit.
// Operands are captured on an accepted start and added one bit pair per clock,
// LSB first; the sum is reassembled in a right-shifting register.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start         : request; accepted only while idle (busy low, done low)
//   a_in, b_in    : operands, captured on the accepting edge
//   cin           : carry-in, captured on the accepting edge
//   busy          : high in SHIFT and DONE
//   done          : one-cycle pulse, sum/cout valid while high
//   sum, cout     : result; held until the next accepted start
//   dbg_state_o   : current FSM state, for observation
//
// Handshake: a start seen in IDLE is accepted on that edge; WIDTH edges later
// done pulses for exactly one cycle. Starts seen while busy are dropped; the
// caller must re-request once busy falls.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_t           dbg_state_o
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;
    logic             bit_s;
    logic             bit_c;

    adder_1bit u_bit (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (bit_s),
        .co (bit_c)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts the LSB
    // computed first has arrived at bit 0.
    assign sum_d = {bit_s, sum_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sum_q   <= sum_d;
                    carry_q <= bit_c;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    if (cnt_q == LAST) begin
                        // Counter wraps to zero rather than passing WIDTH-1.
                        cnt_q   <= '0;
                        cout_q  <= bit_c;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    state_t       dbg_state;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin         (cin),
        .busy        (busy),
        .done        (done),
        .sum         (sum),
        .cout        (cout),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_done   = 0;
    int         n_issued = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected result per done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", {cout, sum}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int k;
        @(posedge clk); #1;
        for (k = 0; k < 50; k++) begin
            if (!busy && !done) return;
            @(posedge clk); #1;
        end
        check("wait_idle_timeout", 1, 0);
    endtask

    // Issue one op; optionally pulse start with junk operands at shift cycle 'poke'.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W:0] exp, input int poke);
        wait_idle();
        start = 1'b1; a_in = a; b_in = b; cin = c;
        exp_q.push_back(exp);
        n_issued++;
        @(posedge clk); #1;                         // just after accept edge E0
        start = 1'b0;
        a_in  = W'($urandom_range(0, 255));         // late operand changes must not matter
        b_in  = W'($urandom_range(0, 255));
        cin   = ~c;
        check("busy_after_accept", busy, 1);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;                     // just after E0+i
            if (poke > 0 && i == poke) begin
                start = 1'b1;
                a_in  = 8'h11;
            end else begin
                start = 1'b0;
            end
            check("done_timing", done, (i == W) ? 1 : 0);
            check("busy_timing", busy, 1);
        end
        start = 1'b0;
        @(posedge clk); #1;                         // just after E0+W+1
        check("done_width", done, 0);
        check("busy_release", busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        check("reset_state", dbg_state, S_IDLE);
        @(negedge clk); rst = 1'b0;

        // Directed vectors
        run_op(8'h5A, 8'h3C, 1'b0, 9'h096, 0);
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, 0);
        run_op(8'hFF, 8'h00, 1'b1, 9'h100, 0);
        run_op(8'h00, 8'h00, 1'b0, 9'h000, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, 0);
        run_op(8'h80, 8'h80, 1'b0, 9'h100, 0);

        // Start while busy is ignored: one done, first result intact
        run_op(8'h12, 8'h34, 1'b0, 9'h046, 3);
        begin
            int extra = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            check("no_second_done", extra, 0);
        end

        // Reset mid-operation
        wait_idle();
        start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("partial_sum_nonzero", (sum != 0), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_state", dbg_state, S_IDLE);
        @(negedge clk); rst = 1'b0;
        run_op(8'h01, 8'h02, 1'b0, 9'h003, 0);

        // start held high for three back-to-back ops: period WIDTH+2
        wait_idle();
        begin
            logic [W-1:0] va[3] = '{8'h10, 8'hF0, 8'hAA};
            logic [W-1:0] vb[3] = '{8'h20, 8'h20, 8'h55};
            logic         vc[3] = '{1'b0, 1'b1, 1'b1};
            logic [W:0]   ve[3] = '{9'h030, 9'h111, 9'h100};
            start = 1'b1; a_in = va[0]; b_in = vb[0]; cin = vc[0];
            exp_q.push_back(ve[0]);
            n_issued++;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;                 // accept edge of op k
                if (k < 2) begin
                    a_in = va[k+1]; b_in = vb[k+1]; cin = vc[k+1];
                    exp_q.push_back(ve[k+1]);
                    n_issued++;
                end else begin
                    start = 1'b0;
                end
                for (int j = 1; j <= W + 1; j++) begin
                    @(posedge clk); #1;
                    check("held_done_spacing", done, (j == W) ? 1 : 0);
                    check("held_busy", busy, (j == W + 1) ? 0 : 1);
                end
            end
            start = 1'b0;
        end

        // Random operands against a + b + cin
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra, rb;
            logic         rc;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc}, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("done_count", n_done, n_issued);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
